sub_test: RTL and testbench
===========================

Name: sub_test

Overview:
- Registered modular subtractor: Dout = (A − B) mod 2^WIDTH.
- Computed by an explicit ripple-borrow chain, not the `-` operator. Also produces borrow and zero flags.
- Building block for the LEA datapath's modular-subtraction steps, e.g. decryption rounds with ROR and subtraction.
- Default 4-bit instance used for unit bring-up; the same RTL scales to WIDTH=32 for the cipher.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 1..64).

Ports:
- clk  input  1  single system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  A/B are sampled this cycle when high
- A  input  WIDTH  minuend, unsigned
- B  input  WIDTH  subtrahend, unsigned
- Dout  output  WIDTH  registered (A − B) mod 2^WIDTH
- borrow  output  1  registered; 1 when A < B (unsigned)
- zero  output  1  registered; 1 when Dout == 0
- out_valid  output  1  registered; high the cycle after an accepted in_valid

Behaviour:
- Reset, asynchronous on rst rising, held while rst=1: Dout=0, borrow=0, zero=1, out_valid=0.
- Reset mid-operation discards any in-flight result. The first output after rst deasserts requires a fresh in_valid.
- Datapath is combinational ripple-borrow:
  - bit i: d_i = A_i ^ B_i ^ br_i
  - br_(i+1) = (~A_i & B_i) | (~(A_i ^ B_i) & br_i)
  - br_0 = 0
  - borrow = br_WIDTH.
- Latency is 1 cycle. On a rising clk with in_valid=1:
  - Dout <= diff, borrow <= br_WIDTH, zero <= (diff == 0), out_valid <= 1.
- With in_valid=0: Dout/borrow/zero hold their previous values; out_valid <= 0.
- Throughput is one operation per cycle; back-to-back in_valid yields back-to-back out_valid.
- No back-pressure and no ready signal.
- Wrap-around: the result is always truncated to WIDTH bits and never saturates. Example for WIDTH=4: 2 − 8 = 0xA with borrow=1.
- Boundary cases:
  - A == B → Dout=0, zero=1, borrow=0.
  - B == 0 → Dout=A, borrow=0.
  - A == 0, B == 0 → Dout=0, zero=1.
  - A == 0, B == 2^WIDTH−1 → Dout=1, borrow=1.
- X on A/B while in_valid=0 must not propagate to the outputs.

Decomposition:
- Shared package lea_pkg holds:
  - the default width constant (LEA_WORD_W = 32);
  - the unit-test width constant (SUBTEST_W = 4).
- One sub-module, full_sub (1-bit full subtractor: a, b, bin → d, bout), instantiated WIDTH times via generate to form the borrow chain.
- Output registers and flag logic stay in sub_test.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle → Dout=0, zero=1, borrow=0, out_valid=0 immediately. Then A=0, B=0, in_valid=1 → next cycle Dout=0x0, zero=1, borrow=0, out_valid=1.
- No borrow: A=0x8, B=0x4, in_valid=1 → next cycle Dout=0x4, borrow=0, zero=0, out_valid=1.
- Wrap-around: A=0x2, B=0x8 → Dout=0xA, borrow=1, zero=0. Also A=0x8, B=0xE → Dout=0xA, borrow=1.
- Equal operands: A=0x6, B=0x6 → Dout=0x0, zero=1, borrow=0.
- Hold and streaming:
  - Results of back-to-back inputs (8−4, 2−8, 6−6) appear on three consecutive cycles with out_valid=1.
  - Then in_valid=0 with A/B toggling → Dout holds 0x0, out_valid=0.
  - Asserting rst during a stream clears out_valid.
- Exhaustive/regression: all 256 (A,B) pairs for WIDTH=4, plus randomized WIDTH=32 → Dout == (A−B) mod 2^WIDTH, borrow == (A<B), zero == (Dout==0).

Source files
------------

// File: rtl/lea_pkg.sv
// Shared constants for the LEA datapath building blocks.
package lea_pkg;
    localparam int LEA_WORD_W = 32;  // cipher word width
    localparam int SUBTEST_W  = 4;   // narrow width used for unit bring-up
endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    // Difference bit and borrow-out of a single stage
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

// File: rtl/sub_test.sv
// Registered modular subtractor: Dout = (A - B) mod 2^WIDTH, built from an
// explicit ripple-borrow chain, with registered borrow and zero flags.
module sub_test
    import lea_pkg::*;
#(
    parameter int WIDTH = SUBTEST_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Dout,
    output logic             borrow,
    output logic             zero,
    output logic             out_valid
);
    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] diff;

    logic [WIDTH-1:0] dout_d, dout_q;
    logic             borrow_d, borrow_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    assign br[0] = 1'b0;

    // Borrow chain: stage i consumes br[i] and feeds br[i+1]
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_sub u_fs (
            .a    (A[i]),
            .b    (B[i]),
            .bin  (br[i]),
            .d    (diff[i]),
            .bout (br[i+1])
        );
    end

    // Capture a new result only on accepted input; otherwise hold, so
    // garbage on A/B while idle never reaches the outputs
    always_comb begin
        dout_d      = dout_q;
        borrow_d    = borrow_q;
        zero_d      = zero_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            dout_d   = diff;
            borrow_d = br[WIDTH];
            zero_d   = (diff == '0);
        end
    end

    // Output registers; reset shows an all-zero, non-valid result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q      <= '0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            dout_q      <= dout_d;
            borrow_q    <= borrow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Dout      = dout_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_sub_test.sv
// Self-checking bench for sub_test: directed cases, exhaustive 4-bit sweep
// and randomized 32-bit operands against an arithmetic reference model.
module tb_sub_test;
    import lea_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  in_valid4, in_valid32;
    logic [SUBTEST_W-1:0]  a4, b4, dout4;
    logic [LEA_WORD_W-1:0] a32, b32, dout32;
    logic                  borrow4, zero4, ov4, borrow32, zero32, ov32;

    sub_test #(.WIDTH(SUBTEST_W)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .A(a4), .B(b4),
        .Dout(dout4), .borrow(borrow4), .zero(zero4), .out_valid(ov4)
    );

    sub_test #(.WIDTH(LEA_WORD_W)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .A(a32), .B(b32),
        .Dout(dout32), .borrow(borrow32), .zero(zero32), .out_valid(ov32)
    );

    // Reference model state
    logic [SUBTEST_W-1:0]  m4_d;
    logic                  m4_b, m4_z, m4_v;
    logic [LEA_WORD_W-1:0] m32_d;
    logic                  m32_b, m32_z, m32_v;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check4(input string tag);
        chk({tag, ".dout"},   64'(dout4), 64'(m4_d));
        chk({tag, ".borrow"}, 64'(borrow4), 64'(m4_b));
        chk({tag, ".zero"},   64'(zero4), 64'(m4_z));
        chk({tag, ".valid"},  64'(ov4), 64'(m4_v));
    endtask

    task automatic check32(input string tag);
        chk({tag, ".dout"},   64'(dout32), 64'(m32_d));
        chk({tag, ".borrow"}, 64'(borrow32), 64'(m32_b));
        chk({tag, ".zero"},   64'(zero32), 64'(m32_z));
        chk({tag, ".valid"},  64'(ov32), 64'(m32_v));
    endtask

    task automatic model_reset();
        m4_d = '0;  m4_b = 1'b0;  m4_z = 1'b1;  m4_v = 1'b0;
        m32_d = '0; m32_b = 1'b0; m32_z = 1'b1; m32_v = 1'b0;
    endtask

    // One cycle on the 4-bit unit; the 32-bit unit idles
    task automatic step4(input string tag, input logic [SUBTEST_W-1:0] a,
                         input logic [SUBTEST_W-1:0] b, input logic v);
        @(negedge clk);
        a4 = a; b4 = b; in_valid4 = v;
        in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom;
        @(posedge clk);
        if (v) begin
            m4_d = a - b;
            m4_b = (a < b);
            m4_z = (m4_d == 0);
        end
        m4_v  = v;
        m32_v = 1'b0;
        #1 check4(tag);
    endtask

    // One cycle on the 32-bit unit; the 4-bit unit idles
    task automatic step32(input string tag, input logic [LEA_WORD_W-1:0] a,
                          input logic [LEA_WORD_W-1:0] b, input logic v);
        @(negedge clk);
        a32 = a; b32 = b; in_valid32 = v;
        in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        @(posedge clk);
        if (v) begin
            m32_d = a - b;
            m32_b = (a < b);
            m32_z = (m32_d == 0);
        end
        m32_v = v;
        m4_v  = 1'b0;
        #1 check32(tag);
    endtask

    // Assert reset mid-cycle, check outputs cleared at once, then release
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check4({tag, ".r4"});
        check32({tag, ".r32"});
        @(negedge clk);
        in_valid4 = 1'b0; in_valid32 = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        in_valid4 = 1'b0; in_valid32 = 1'b0;
        a4 = '0; b4 = '0; a32 = '0; b32 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check4("por");
        @(negedge clk) rst = 1'b0;

        async_reset("rst0");
        step4("zero_zero", 4'h0, 4'h0, 1'b1);
        step4("no_borrow", 4'h8, 4'h4, 1'b1);
        step4("wrap_2_8",  4'h2, 4'h8, 1'b1);
        step4("wrap_8_e",  4'h8, 4'hE, 1'b1);
        step4("equal",     4'h6, 4'h6, 1'b1);
        step4("b_zero",    4'h9, 4'h0, 1'b1);
        step4("a0_bmax",   4'h0, 4'hF, 1'b1);

        // back-to-back stream, then idle with toggling operands
        step4("s0", 4'h8, 4'h4, 1'b1);
        step4("s1", 4'h2, 4'h8, 1'b1);
        step4("s2", 4'h6, 4'h6, 1'b1);
        for (int i = 0; i < 4; i++)
            step4("idle", 4'($urandom), 4'($urandom), 1'b0);

        // reset during a stream discards the in-flight result
        step4("pre_rst", 4'h3, 4'h1, 1'b1);
        @(negedge clk);
        a4 = 4'h7; b4 = 4'h2; in_valid4 = 1'b1;
        #2 rst = 1'b1;
        #1 model_reset();
        check4("rst_stream");
        @(negedge clk);
        in_valid4 = 1'b0;
        rst = 1'b0;
        step4("post_rst_idle", 4'h5, 4'h1, 1'b0);

        // exhaustive 4-bit sweep with occasional bubbles
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                step4("sweep", 4'(a), 4'(b), 1'b1);
                if (((a + b) % 7) == 0)
                    step4("bubble", 4'($urandom), 4'($urandom), 1'b0);
            end

        // 32-bit boundaries then random operands
        step32("w_eq",   32'h1234_5678, 32'h1234_5678, 1'b1);
        step32("w_a0",   32'h0, 32'hFFFF_FFFF, 1'b1);
        step32("w_b0",   32'hDEAD_BEEF, 32'h0, 1'b1);
        for (int i = 0; i < 300; i++)
            step32("w_rand", $urandom, $urandom, ($urandom_range(0, 3) != 0));

        async_reset("rst_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
